instr_decode_stage: RTL and testbench

- Parametrised, registered successor to the combinational instruction field splitter.
- Accepts 32-bit instruction words from fetch over a valid/ready handshake.
- Extracts opcode, destination, source-register and immediate fields at parametrised bit positions, zero-extends register indices to FIELD_W, and presents them registered to the register-file/ALU side.
- A 2-entry skid buffer gives full throughput with a registered in_ready. A synchronous flush supports branch/jump redirect.

---
 rtl/instr_fmt_pkg.sv | 35 +++
 rtl/instr_field_extract.sv | 32 +++
 rtl/instr_decode_stage.sv | 118 +++++++++++
 tb/tb_instr_decode_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fmt_pkg.sv
// Shared instruction-format constants and the buffered entry type for the
// decode stage. Optional reserved-bit check is enabled with DECODE_CHECK_EN.
package instr_fmt_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_W   = 8;
  localparam int REG_ADDR_W = 3;
  localparam int FIELD_W    = 8;
  localparam int IMM_W      = 8;
  localparam int DEST_LSB   = 16;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_LSB   = 0;

  // One buffered instruction: occupancy flag, raw word, precomputed check bit.
  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] word;
    logic               illegal;
  } instr_entry_t;

  // True when any bit between the destination field and the opcode, or
  // between the source-1 field and the destination field, is set.
  function automatic logic reserved_nonzero(input logic [INSTR_W-1:0] w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < INSTR_W; i++) begin
      if ((i >= DEST_LSB + REG_ADDR_W && i <= INSTR_W - OPCODE_W - 1) ||
          (i >= SRC1_LSB + REG_ADDR_W && i <= DEST_LSB - 1)) begin
        r = r | w[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_field_extract.sv
// Pure combinational splitter: pulls opcode, register indices and immediate
// out of one instruction word. Register indices are zero-extended.
module instr_field_extract #(
  parameter int INSTR_W    = instr_fmt_pkg::INSTR_W,
  parameter int OPCODE_W   = instr_fmt_pkg::OPCODE_W,
  parameter int REG_ADDR_W = instr_fmt_pkg::REG_ADDR_W,
  parameter int FIELD_W    = instr_fmt_pkg::FIELD_W,
  parameter int IMM_W      = instr_fmt_pkg::IMM_W,
  parameter int DEST_LSB   = instr_fmt_pkg::DEST_LSB,
  parameter int SRC1_LSB   = instr_fmt_pkg::SRC1_LSB,
  parameter int SRC2_LSB   = instr_fmt_pkg::SRC2_LSB
) (
  input  logic [INSTR_W-1:0]  word,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FIELD_W-1:0]  write_reg,
  output logic [FIELD_W-1:0]  read_reg1,
  output logic [FIELD_W-1:0]  read_reg2,
  output logic [IMM_W-1:0]    immediate
);

  localparam int PAD_W = FIELD_W - REG_ADDR_W;

  // Immediate deliberately overlaps the source-2 field; both are driven.
  always_comb begin
    opcode    = word[INSTR_W-1 -: OPCODE_W];
    write_reg = {{PAD_W{1'b0}}, word[DEST_LSB +: REG_ADDR_W]};
    read_reg1 = {{PAD_W{1'b0}}, word[SRC1_LSB +: REG_ADDR_W]};
    read_reg2 = {{PAD_W{1'b0}}, word[SRC2_LSB +: REG_ADDR_W]};
    immediate = word[IMM_W-1:0];
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage with a 2-entry skid buffer and
// synchronous flush. Define DECODE_CHECK_EN to flag reserved-bit violations.
//
// Handshake: a word transfers on a rising edge where valid && ready are both
// high on that side (accept = in_valid && in_ready, emit = out_valid &&
// out_ready). in_ready comes straight from a flop and is low exactly while the
// skid entry is occupied; outputs hold steady while out_valid && !out_ready.
module instr_decode_stage #(
  parameter int INSTR_W    = instr_fmt_pkg::INSTR_W,
  parameter int OPCODE_W   = instr_fmt_pkg::OPCODE_W,
  parameter int REG_ADDR_W = instr_fmt_pkg::REG_ADDR_W,
  parameter int FIELD_W    = instr_fmt_pkg::FIELD_W,
  parameter int IMM_W      = instr_fmt_pkg::IMM_W,
  parameter int DEST_LSB   = instr_fmt_pkg::DEST_LSB,
  parameter int SRC1_LSB   = instr_fmt_pkg::SRC1_LSB,
  parameter int SRC2_LSB   = instr_fmt_pkg::SRC2_LSB
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [FIELD_W-1:0]  out_write_reg,
  output logic [FIELD_W-1:0]  out_read_reg1,
  output logic [FIELD_W-1:0]  out_read_reg2,
  output logic [IMM_W-1:0]    out_immediate,
  output logic                out_illegal,
  output logic [1:0]          occupancy
);

  import instr_fmt_pkg::*;

  instr_entry_t main_q, main_n;
  instr_entry_t skid_q, skid_n;
  instr_entry_t new_entry;
  logic         in_ready_q;
  logic         accept;
  logic         emit;

  assign accept = in_valid && in_ready_q;
  assign emit   = main_q.valid && out_ready;

  // Build the entry for an incoming word; the check bit is settled at accept.
  always_comb begin
    new_entry.valid = 1'b1;
    new_entry.word  = in_instr;
`ifdef DECODE_CHECK_EN
    new_entry.illegal = reserved_nonzero(in_instr);
`else
    new_entry.illegal = 1'b0;
`endif
  end

  // Next contents of main/skid; flush wins, otherwise strict FIFO movement.
  always_comb begin
    main_n = main_q;
    skid_n = skid_q;
    if (flush) begin
      main_n.valid = 1'b0;
      skid_n.valid = 1'b0;
    end else if (!main_q.valid) begin
      if (accept) main_n = new_entry;
    end else if (emit) begin
      if (skid_q.valid) begin
        main_n = skid_q;
        if (accept) skid_n = new_entry;
        else        skid_n.valid = 1'b0;
      end else if (accept) begin
        main_n = new_entry;
      end else begin
        main_n.valid = 1'b0;
      end
    end else if (accept) begin
      skid_n = new_entry;
    end
  end

  // State registers; in_ready tracks the next skid occupancy so it is a flop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      in_ready_q <= !skid_n.valid;
    end
  end

  instr_field_extract #(
    .INSTR_W    (INSTR_W),
    .OPCODE_W   (OPCODE_W),
    .REG_ADDR_W (REG_ADDR_W),
    .FIELD_W    (FIELD_W),
    .IMM_W      (IMM_W),
    .DEST_LSB   (DEST_LSB),
    .SRC1_LSB   (SRC1_LSB),
    .SRC2_LSB   (SRC2_LSB)
  ) u_extract (
    .word      (main_q.word),
    .opcode    (out_opcode),
    .write_reg (out_write_reg),
    .read_reg1 (out_read_reg1),
    .read_reg2 (out_read_reg2),
    .immediate (out_immediate)
  );

  assign in_ready    = in_ready_q;
  assign out_valid   = main_q.valid;
  assign out_illegal = main_q.valid && main_q.illegal;
  assign occupancy   = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed cases plus a long
// random run against a depth-2 FIFO reference model.
module tb_instr_decode_stage;

  logic        CLK;
  logic        RESET_N;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [7:0]  out_write_reg;
  logic [7:0]  out_read_reg1;
  logic [7:0]  out_read_reg2;
  logic [7:0]  out_immediate;
  logic        out_illegal;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  instr_decode_stage dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_write_reg (out_write_reg),
    .out_read_reg1 (out_read_reg1),
    .out_read_reg2 (out_read_reg2),
    .out_immediate (out_immediate),
    .out_illegal   (out_illegal),
    .occupancy     (occupancy)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
  endtask

  // reference decode written straight from the field layout
  function automatic logic [7:0] ref_opcode(input logic [31:0] w);
    return 8'((w >> 24) & 32'hFF);
  endfunction
  function automatic logic [7:0] ref_reg(input logic [31:0] w, input int lsb);
    return 8'((w >> lsb) & 32'h7);
  endfunction
  function automatic logic [7:0] ref_imm(input logic [31:0] w);
    return 8'(w & 32'hFF);
  endfunction
  function automatic logic ref_illegal(input logic [31:0] w);
`ifdef DECODE_CHECK_EN
    return (((w >> 19) & 32'h1F) != 0) || (((w >> 11) & 32'h1F) != 0);
`else
    return (w != w);
`endif
  endfunction

  // scoreboard comparison of every output against the FIFO model
  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("occupancy", 32'(occupancy), 32'(sz));
    check("in_ready",  32'(in_ready),  32'(sz < 2));
    check("out_valid", 32'(out_valid), 32'(sz > 0));
    if (sz > 0) begin
      check("opcode",    32'(out_opcode),    32'(ref_opcode(exp_q[0])));
      check("write_reg", 32'(out_write_reg), 32'(ref_reg(exp_q[0], 16)));
      check("read_reg1", 32'(out_read_reg1), 32'(ref_reg(exp_q[0], 8)));
      check("read_reg2", 32'(out_read_reg2), 32'(ref_reg(exp_q[0], 0)));
      check("immediate", 32'(out_immediate), 32'(ref_imm(exp_q[0])));
      check("illegal",   32'(out_illegal),   32'(ref_illegal(exp_q[0])));
    end else begin
      check("illegal_idle", 32'(out_illegal), 32'd0);
    end
  endtask

  // driver: one cycle, called and returning at a falling edge
  task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    bit acc, emi;
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    acc = v && (exp_q.size() < 2);
    emi = (exp_q.size() > 0) && ordy;
    @(posedge CLK);
    if (fl) exp_q.delete();
    else begin
      if (emi) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(w);
    end
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},  32'(out_valid),     32'd0);
    check({tag, "_ready"},  32'(in_ready),      32'd1);
    check({tag, "_occ"},    32'(occupancy),     32'd0);
    check({tag, "_opcode"}, 32'(out_opcode),    32'd0);
    check({tag, "_wreg"},   32'(out_write_reg), 32'd0);
    check({tag, "_rreg1"},  32'(out_read_reg1), 32'd0);
    check({tag, "_rreg2"},  32'(out_read_reg2), 32'd0);
    check({tag, "_imm"},    32'(out_immediate), 32'd0);
    check({tag, "_ill"},    32'(out_illegal),   32'd0);
  endtask

  initial begin
    logic [31:0] words[3];
    int idx;
    logic seen_flushed;

    RESET_N = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_outputs();

    // basic field split
    step(1'b1, 32'h01020304, 1'b1, 1'b0);
    check("t1_opcode", 32'(out_opcode),    32'h01);
    check("t1_wreg",   32'(out_write_reg), 32'h02);
    check("t1_rreg1",  32'(out_read_reg1), 32'h03);
    check("t1_rreg2",  32'(out_read_reg2), 32'h04);
    check("t1_imm",    32'(out_immediate), 32'h04);

    // zero extension and reserved-bit check
    step(1'b1, 32'hFF07FFFF, 1'b1, 1'b0);
    check("t2_wreg",  32'(out_write_reg), 32'h07);
    check("t2_rreg1", 32'(out_read_reg1), 32'h07);
    check("t2_rreg2", 32'(out_read_reg2), 32'h07);
    check("t2_imm",   32'(out_immediate), 32'hFF);
`ifdef DECODE_CHECK_EN
    check("t2_ill", 32'(out_illegal), 32'd1);
`else
    check("t2_ill", 32'(out_illegal), 32'd0);
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_empty", 32'(occupancy), 32'd0);

    // A, B, C back to back with the consumer stalled, then released
    words[0] = 32'h10010203; words[1] = 32'h20040506; words[2] = 32'h30070001;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      bit acc;
      acc = (exp_q.size() < 2);
      step(1'b1, words[idx], 1'b0, 1'b0);
      if (acc) idx++;
    end
    check("abc_accepted", 32'(idx),      32'd2);
    check("abc_ready",    32'(in_ready), 32'd0);
    check("abc_occ",      32'(occupancy), 32'd2);
    check("abc_head",     32'(out_opcode), 32'h10);
    for (int c = 0; c < 3; c++) begin
      check("abc_nobubble", 32'(out_valid), 32'd1);
      check("abc_order", 32'(out_opcode), 32'(ref_opcode(words[c])));
      step(idx < 3, words[idx < 3 ? idx : 2], 1'b1, 1'b0);
      if (idx < 3 && exp_q.size() > 0 && exp_q[exp_q.size()-1] == words[idx]) idx++;
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("abc_drained", 32'(out_valid), 32'd0);

    // flush with a full buffer and a word on offer
    step(1'b1, 32'h41000000, 1'b0, 1'b0);
    step(1'b1, 32'h42000000, 1'b0, 1'b0);
    check("fl_full", 32'(occupancy), 32'd2);
    step(1'b1, 32'h43000000, 1'b1, 1'b1);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_occ",   32'(occupancy), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    seen_flushed = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (out_valid && out_opcode >= 8'h41 && out_opcode <= 8'h43) seen_flushed = 1'b1;
    end
    check("fl_never_emitted", 32'(seen_flushed), 32'd0);

    // asynchronous reset in the middle of traffic
    step(1'b1, 32'h51020304, 1'b0, 1'b0);
    step(1'b1, 32'h52050607, 1'b0, 1'b0);
    check("rst_pre_occ", 32'(occupancy), 32'd2);
    #2 RESET_N = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    in_valid = 1'b0;
    @(negedge CLK);
    check_outputs();

    // random traffic against the FIFO model
    for (int c = 0; c < 10000; c++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = w & 32'hFF070707;
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
